wb_queue: RTL and testbench

Two-lane writeback queue sitting directly upstream of the 2-write/4-read flip-flop register file. It accepts up to two completed results per cycle from the execution units, buffers them in order, and drains up to two per cycle onto the register file's two write ports. It removes same-destination (WAW) conflicts before the register file sees them, so the register file never receives two writes to the same register in one cycle.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_queue_mem.sv | 35 +++
 rtl/wb_queue.sv | 124 ++++++++++++
 tb/tb_wb_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_pkg : default widths and entry type for the writeback queue   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package wb_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DEPTH          = 8;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/wb_queue_mem.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_queue_mem : 2-write / 2-read flip-flop entry storage          |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module wb_queue_mem
  import wb_pkg::*;
#(
  parameter int N_ENTRIES = wb_pkg::DEPTH
) (
  input  logic                         clk,
  input  logic                         we1,
  input  logic [$clog2(N_ENTRIES)-1:0] waddr1,
  input  wb_entry_t                    wdata1,
  input  logic                         we2,
  input  logic [$clog2(N_ENTRIES)-1:0] waddr2,
  input  wb_entry_t                    wdata2,
  input  logic [$clog2(N_ENTRIES)-1:0] rd_ptr,
  output wb_entry_t                    rdata0,
  output wb_entry_t                    rdata1
);
  localparam int c_ptr_w = $clog2(N_ENTRIES);

  // Storage is intentionally left unreset; validity is tracked by the pointers.
  wb_entry_t r_mem [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (we1) r_mem[waddr1] <= wdata1;
    if (we2) r_mem[waddr2] <= wdata2;
  end

  assign rdata0 = r_mem[rd_ptr];
  assign rdata1 = r_mem[rd_ptr + c_ptr_w'(1)];
endmodule
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_queue : two-lane in-order writeback queue with WAW merge      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module wb_queue #(
  parameter int DATA_WIDTH     = wb_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = wb_pkg::REG_ADDR_WIDTH,
  parameter int DEPTH          = wb_pkg::DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq1_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] enq1_addr_i,
  input  logic [DATA_WIDTH-1:0]     enq1_data_i,
  input  logic                      enq2_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] enq2_addr_i,
  input  logic [DATA_WIDTH-1:0]     enq2_data_i,
  output logic                      enq_ready_o,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      write1_en_o,
  output logic [REG_ADDR_WIDTH-1:0] write1_addr_o,
  output logic [DATA_WIDTH-1:0]     data1_o,
  output logic                      write2_en_o,
  output logic [REG_ADDR_WIDTH-1:0] write2_addr_o,
  output logic [DATA_WIDTH-1:0]     data2_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o
);
  import wb_pkg::*;

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [c_ptr_w-1:0]        r_head, r_tail;
  logic [c_cnt_w-1:0]        r_count;
  logic                      r_overflow;
  logic                      r_wr1_en, r_wr2_en;
  logic [REG_ADDR_WIDTH-1:0] r_wr1_addr, r_wr2_addr;
  logic [DATA_WIDTH-1:0]     r_wr1_data, r_wr2_data;

  wb_entry_t  w_lane1, w_lane2, w_rd0, w_rd1;
  logic       w_acc1, w_acc2, w_drain, w_pop2, w_waw;
  logic [1:0] w_n_enq, w_n_deq;

  // Ready depends on registered occupancy only, so freed slots are not reused same-cycle.
  assign enq_ready_o = (c_cnt_w'(DEPTH) - r_count) >= c_cnt_w'(2);
  assign w_acc1      = enq1_valid_i & enq_ready_o;
  assign w_acc2      = enq2_valid_i & enq_ready_o;
  assign w_n_enq     = {1'b0, w_acc1} + {1'b0, w_acc2};
  assign w_lane1     = {enq1_addr_i, enq1_data_i};
  assign w_lane2     = {enq2_addr_i, enq2_data_i};

  assign w_drain = ~stall_i & ~flush_i & (r_count != '0);
  assign w_pop2  = w_drain & (r_count >= c_cnt_w'(2));
  assign w_n_deq = {w_pop2, w_drain & ~w_pop2};
  assign w_waw   = w_pop2 & (w_rd0.addr == w_rd1.addr);

  wb_queue_mem #(
    .N_ENTRIES (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we1    (w_acc1 & ~flush_i),
    .waddr1 (r_tail),
    .wdata1 (w_lane1),
    .we2    (w_acc2 & ~flush_i),
    .waddr2 (r_tail + c_ptr_w'(w_acc1)),
    .wdata2 (w_lane2),
    .rd_ptr (r_head),
    .rdata0 (w_rd0),
    .rdata1 (w_rd1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_wr1_en   <= 1'b0;
      r_wr2_en   <= 1'b0;
      r_wr1_addr <= '0;
      r_wr2_addr <= '0;
      r_wr1_data <= '0;
      r_wr2_data <= '0;
    end else begin
      if ((enq1_valid_i | enq2_valid_i) & ~enq_ready_o)
        r_overflow <= 1'b1;
      if (flush_i) begin
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        r_wr1_en <= 1'b0;
        r_wr2_en <= 1'b0;
      end else begin
        r_tail   <= r_tail + c_ptr_w'(w_n_enq);
        r_head   <= r_head + c_ptr_w'(w_n_deq);
        r_count  <= r_count + c_cnt_w'(w_n_enq) - c_cnt_w'(w_n_deq);
        r_wr1_en <= w_drain;
        r_wr2_en <= w_pop2 & ~w_waw;
        // On a WAW pair the younger entry wins and goes out on port 1.
        if (w_drain) begin
          r_wr1_addr <= w_waw ? w_rd1.addr : w_rd0.addr;
          r_wr1_data <= w_waw ? w_rd1.data : w_rd0.data;
        end
        if (w_pop2 & ~w_waw) begin
          r_wr2_addr <= w_rd1.addr;
          r_wr2_data <= w_rd1.data;
        end
      end
    end
  end

  assign write1_en_o   = r_wr1_en;
  assign write1_addr_o = r_wr1_addr;
  assign data1_o       = r_wr1_data;
  assign write2_en_o   = r_wr2_en;
  assign write2_addr_o = r_wr2_addr;
  assign data2_o       = r_wr2_data;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_wb_queue : directed + scoreboard bench for wb_queue           |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_wb_queue;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        enq1_valid_i, enq2_valid_i;
  logic [4:0]  enq1_addr_i, enq2_addr_i;
  logic [31:0] enq1_data_i, enq2_data_i;
  logic        enq_ready_o, stall_i, flush_i;
  logic        write1_en_o, write2_en_o;
  logic [4:0]  write1_addr_o, write2_addr_o;
  logic [31:0] data1_o, data2_o;
  logic [3:0]  count_o;
  logic        overflow_o;

  int checks;
  int failures;

  wb_entry_t   mq[$];
  logic        e_en1, e_en2, e_ovf;
  logic [4:0]  e_a1, e_a2;
  logic [31:0] e_d1, e_d2;

  wb_queue dut (
    .clk           (clk),
    .rst           (rst),
    .enq1_valid_i  (enq1_valid_i),
    .enq1_addr_i   (enq1_addr_i),
    .enq1_data_i   (enq1_data_i),
    .enq2_valid_i  (enq2_valid_i),
    .enq2_addr_i   (enq2_addr_i),
    .enq2_data_i   (enq2_data_i),
    .enq_ready_o   (enq_ready_o),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .write1_en_o   (write1_en_o),
    .write1_addr_o (write1_addr_o),
    .data1_o       (data1_o),
    .write2_en_o   (write2_en_o),
    .write2_addr_o (write2_addr_o),
    .data2_o       (data2_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit v2, input logic [4:0] a2, input logic [31:0] d2,
                       input bit st, input bit fl);
    enq1_valid_i = v1; enq1_addr_i = a1; enq1_data_i = d1;
    enq2_valid_i = v2; enq2_addr_i = a2; enq2_data_i = d2;
    stall_i = st; flush_i = fl;
  endtask

  task automatic model_reset();
    mq.delete();
    e_en1 = 0; e_en2 = 0; e_ovf = 0;
    e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
  endtask

  // Advance one clock edge, update the reference model, compare every output.
  task automatic tick();
    bit v1, v2, st, fl, rdy;
    int sz;
    wb_entry_t l1, l2, x0, x1;
    v1 = enq1_valid_i; v2 = enq2_valid_i; st = stall_i; fl = flush_i;
    l1 = {enq1_addr_i, enq1_data_i};
    l2 = {enq2_addr_i, enq2_data_i};
    sz = mq.size();
    rdy = (DEPTH - sz) >= 2;
    @(posedge clk); #1;
    e_en1 = 0; e_en2 = 0;
    if ((v1 || v2) && !rdy) e_ovf = 1;
    if (fl) mq.delete();
    else begin
      if (!st && sz > 0) begin
        if (sz >= 2) begin
          x0 = mq.pop_front(); x1 = mq.pop_front();
          if (x0.addr == x1.addr) begin
            e_en1 = 1; e_a1 = x1.addr; e_d1 = x1.data;
          end else begin
            e_en1 = 1; e_a1 = x0.addr; e_d1 = x0.data;
            e_en2 = 1; e_a2 = x1.addr; e_d2 = x1.data;
          end
        end else begin
          x0 = mq.pop_front();
          e_en1 = 1; e_a1 = x0.addr; e_d1 = x0.data;
        end
      end
      if (rdy) begin
        if (v1) mq.push_back(l1);
        if (v2) mq.push_back(l2);
      end
    end
    chk("wr1_en",   write1_en_o,   e_en1);
    chk("wr1_addr", write1_addr_o, e_a1);
    chk("wr1_data", data1_o,       e_d1);
    chk("wr2_en",   write2_en_o,   e_en2);
    chk("wr2_addr", write2_addr_o, e_a2);
    chk("wr2_data", data2_o,       e_d2);
    chk("count",    count_o,       mq.size());
    chk("ready",    enq_ready_o,   (DEPTH - mq.size()) >= 2);
    chk("overflow", overflow_o,    e_ovf);
  endtask

  initial begin
    checks = 0; failures = 0;
    model_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr1_en", write1_en_o, 0);
    chk("rst_wr2_en", write2_en_o, 0);
    chk("rst_addr1",  write1_addr_o, 0);
    chk("rst_data1",  data1_o, 0);
    chk("rst_count",  count_o, 0);
    chk("rst_ovf",    overflow_o, 0);
    rst = 1'b1;
    chk("rst_ready",  enq_ready_o, 1);

    // lane 1 only
    drive(1, 5'd3, 32'h11, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("t1_wr1_en", write1_en_o, 1);
    chk("t1_addr1",  write1_addr_o, 3);
    chk("t1_data1",  data1_o, 32'h11);
    chk("t1_wr2_en", write2_en_o, 0);
    chk("t1_count",  count_o, 0);
    tick();

    // both lanes, distinct destinations
    drive(1, 5'd4, 32'hA, 1, 5'd5, 32'hB, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("t2_wr1_en", write1_en_o, 1);
    chk("t2_addr1",  write1_addr_o, 4);
    chk("t2_data1",  data1_o, 32'hA);
    chk("t2_wr2_en", write2_en_o, 1);
    chk("t2_addr2",  write2_addr_o, 5);
    chk("t2_data2",  data2_o, 32'hB);
    tick();

    // WAW on r7
    drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("waw_wr1_en", write1_en_o, 1);
    chk("waw_addr1",  write1_addr_o, 7);
    chk("waw_data1",  data1_o, 32'h2);
    chk("waw_wr2_en", write2_en_o, 0);
    tick();

    // fill under stall, then drop a pair, then drain across wrap
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(8 + 2*i), 32'h100 + 32'(i), 1, 5'(9 + 2*i), 32'h200 + 32'(i), 1, 0);
      tick();
    end
    chk("fill_count", count_o, 8);
    chk("fill_ready", enq_ready_o, 0);
    drive(1, 5'd30, 32'hDEAD, 1, 5'd31, 32'hBEEF, 1, 0); tick();
    chk("fill_ovf", overflow_o, 1);
    chk("fill_count_hold", count_o, 8);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("drain_count", count_o, 0);

    // flush with count 5 plus a concurrent pair
    drive(1, 5'd1, 32'h51, 1, 5'd2, 32'h52, 1, 0); tick();
    drive(1, 5'd3, 32'h53, 1, 5'd4, 32'h54, 1, 0); tick();
    drive(1, 5'd5, 32'h55, 0, 0, 0, 1, 0); tick();
    chk("pre_flush_count", count_o, 5);
    drive(1, 5'd6, 32'h56, 1, 5'd9, 32'h57, 0, 1); tick();
    chk("flush_count", count_o, 0);
    chk("flush_wr1_en", write1_en_o, 0);
    chk("flush_ovf", overflow_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("flush_discard", write1_en_o, 0);

    // sustained random traffic with small address range to provoke WAW
    for (int i = 0; i < 24; i++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 3) == 0), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    // asynchronous reset in the middle of a drain
    drive(1, 5'd20, 32'hC0, 1, 5'd21, 32'hC1, 1, 0); tick();
    drive(1, 5'd22, 32'hC2, 0, 0, 0, 1, 0); tick();
    chk("pre_rst_count", count_o, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_wr1_en", write1_en_o, 0);
    chk("arst_wr2_en", write2_en_o, 0);
    chk("arst_addr1",  write1_addr_o, 0);
    chk("arst_data2",  data2_o, 0);
    chk("arst_count",  count_o, 0);
    chk("arst_ovf",    overflow_o, 0);
    #1 rst = 1'b1;
    chk("arst_ready", enq_ready_o, 1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
